overflow_monitor: RTL and testbench



---
 rtl/overflow_monitor.sv | 130 +++++++++++++
 tb/tb_overflow_monitor.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/overflow_monitor.sv
// Overflow monitor: registers the accumulator sum and overflow bit, counts overflow
// rising edges (saturating), flags a high sum level and drives a timed alarm FSM.
module overflow_monitor #(
  parameter int DATA_W = 6,
  parameter int CNT_W  = 8,
  parameter int THRESH = 48,
  parameter int HOLD   = 4
) (
  input  logic              clock,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_overflow,
  input  logic              i_clear,
  output logic [CNT_W-1:0]  o_ovf_count,
  output logic              o_sticky,
  output logic              o_high,
  output logic              o_alarm,
  output logic [1:0]        o_state
);

  localparam int TMR_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(HOLD - 1);
  localparam logic [DATA_W-1:0] THRESH_V = DATA_W'(THRESH);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ARMED    = 2'd1;
  localparam logic [1:0] S_ALARM    = 2'd2;
  localparam logic [1:0] S_COOLDOWN = 2'd3;

  logic [DATA_W-1:0] r_data;
  logic              r_ovf;
  logic              r_ovf_d;
  logic              ovf_rise;
  logic              at_thresh;

  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic [TMR_W-1:0]  timer_reg;
  logic [TMR_W-1:0]  timer_next;
  logic [CNT_W-1:0]  count_next;
  logic              sticky_next;

  assign ovf_rise  = r_ovf & ~r_ovf_d;
  assign at_thresh = (r_data >= THRESH_V);

  // Input stage and level flag are never touched by i_clear.
  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_ovf   <= 1'b0;
      r_ovf_d <= 1'b0;
      o_high  <= 1'b0;
    end else begin
      r_data  <= i_data;
      r_ovf   <= i_overflow;
      r_ovf_d <= r_ovf;
      o_high  <= at_thresh;
    end
  end

  always_comb begin
    count_next  = o_ovf_count;
    sticky_next = o_sticky;
    if (i_clear) begin
      count_next  = '0;
      sticky_next = 1'b0;
    end else if (ovf_rise) begin
      sticky_next = 1'b1;
      if (o_ovf_count != CNT_MAX) begin
        count_next = o_ovf_count + CNT_W'(1);
      end
    end
  end

  // A rise from any state (re)enters ALARM with a full hold period.
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    if (i_clear) begin
      state_next = S_IDLE;
      timer_next = '0;
    end else if (ovf_rise) begin
      state_next = S_ALARM;
      timer_next = TMR_LOAD;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (at_thresh) state_next = S_ARMED;
        end
        S_ARMED: begin
          if (!at_thresh) state_next = S_IDLE;
        end
        S_ALARM: begin
          if (timer_reg == '0) begin
            state_next = S_COOLDOWN;
          end else begin
            timer_next = timer_reg - TMR_W'(1);
          end
        end
        S_COOLDOWN: begin
          if (!r_ovf) state_next = S_IDLE;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ovf_count <= '0;
      o_sticky    <= 1'b0;
      state_reg   <= S_IDLE;
      timer_reg   <= '0;
    end else begin
      o_ovf_count <= count_next;
      o_sticky    <= sticky_next;
      state_reg   <= state_next;
      timer_reg   <= timer_next;
    end
  end

  // Decoded straight from the state so an asynchronous reset drops it at once.
  assign o_alarm = (state_reg == S_ALARM);
  assign o_state = state_reg;

endmodule

// File: tb/tb_overflow_monitor.sv
// Directed self-checking bench for overflow_monitor with hand-computed expectations.
module tb_overflow_monitor;

  logic       clock;
  logic       i_rst_n;
  logic [5:0] i_data;
  logic       i_overflow;
  logic       i_clear;
  logic [7:0] o_ovf_count;
  logic       o_sticky;
  logic       o_high;
  logic       o_alarm;
  logic [1:0] o_state;

  int total = 0;
  int bad   = 0;
  int alarm_cycles;

  overflow_monitor #(
    .DATA_W(6),
    .CNT_W (8),
    .THRESH(48),
    .HOLD  (4)
  ) dut (
    .clock      (clock),
    .i_rst_n    (i_rst_n),
    .i_data     (i_data),
    .i_overflow (i_overflow),
    .i_clear    (i_clear),
    .o_ovf_count(o_ovf_count),
    .o_sticky   (o_sticky),
    .o_high     (o_high),
    .o_alarm    (o_alarm),
    .o_state    (o_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse();
    i_overflow = 1'b1;
    tick();
    i_overflow = 1'b0;
    tick();
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
  endtask

  initial begin
    i_rst_n    = 1'b0;
    i_data     = '0;
    i_overflow = 1'b0;
    i_clear    = 1'b0;
    repeat (3) tick();
    i_rst_n = 1'b1;
    check("rst_count",  32'(o_ovf_count), 32'd0);
    check("rst_sticky", 32'(o_sticky),    32'd0);
    check("rst_high",   32'(o_high),      32'd0);
    check("rst_alarm",  32'(o_alarm),     32'd0);
    check("rst_state",  32'(o_state),     32'd0);

    // Single overflow held high: sampled at edge 1, alarm edges 2..5.
    i_overflow = 1'b1;
    tick();
    check("ovf_e1_count", 32'(o_ovf_count), 32'd0);
    check("ovf_e1_state", 32'(o_state),     32'd0);
    tick();
    check("ovf_e2_count",  32'(o_ovf_count), 32'd1);
    check("ovf_e2_sticky", 32'(o_sticky),    32'd1);
    check("ovf_e2_state",  32'(o_state),     32'd2);
    check("ovf_e2_alarm",  32'(o_alarm),     32'd1);
    repeat (3) tick();
    check("ovf_e5_alarm", 32'(o_alarm), 32'd1);
    tick();
    check("ovf_e6_alarm", 32'(o_alarm), 32'd0);
    check("ovf_e6_state", 32'(o_state), 32'd3);
    tick();
    check("ovf_e7_state", 32'(o_state), 32'd3);
    i_overflow = 1'b0;
    tick();
    check("cool_hold_state", 32'(o_state), 32'd3);
    tick();
    check("cool_exit_state", 32'(o_state), 32'd0);
    check("ovf_final_count", 32'(o_ovf_count), 32'd1);

    // Threshold 47 -> 48 -> 47 with 2-edge latency on o_high.
    i_data = 6'd47;
    tick();
    i_data = 6'd48;
    tick();
    check("thr_47_high",  32'(o_high),  32'd0);
    check("thr_47_state", 32'(o_state), 32'd0);
    i_data = 6'd47;
    tick();
    check("thr_48_high",  32'(o_high),  32'd1);
    check("thr_48_state", 32'(o_state), 32'd1);
    i_data = 6'd0;
    tick();
    check("thr_back_high",  32'(o_high),  32'd0);
    check("thr_back_state", 32'(o_state), 32'd0);

    // Retrigger two cycles into ALARM: 2 + 4 alarm cycles.
    do_clear();
    check("clr_count",  32'(o_ovf_count), 32'd0);
    check("clr_sticky", 32'(o_sticky),    32'd0);
    i_overflow = 1'b1;
    tick();
    alarm_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      i_overflow = (i == 1);
      tick();
      if (o_alarm) alarm_cycles++;
      if (i == 6) check("retrig_cool_state", 32'(o_state), 32'd3);
    end
    check("retrig_alarm_cycles", 32'(alarm_cycles), 32'd6);
    check("retrig_count",        32'(o_ovf_count),  32'd2);
    check("retrig_end_state",    32'(o_state),      32'd0);

    // Saturation at 255.
    do_clear();
    for (int n = 0; n < 254; n++) pulse();
    check("sat_254", 32'(o_ovf_count), 32'd254);
    pulse();
    check("sat_255", 32'(o_ovf_count), 32'd255);
    for (int n = 0; n < 5; n++) pulse();
    check("sat_hold",   32'(o_ovf_count), 32'd255);
    check("sat_sticky", 32'(o_sticky),    32'd1);

    // Clear colliding with a rise at count 5.
    do_clear();
    i_data = 6'd60;
    for (int n = 0; n < 5; n++) pulse();
    check("coll_pre_count", 32'(o_ovf_count), 32'd5);
    check("coll_pre_high",  32'(o_high),      32'd1);
    i_overflow = 1'b1;
    tick();
    i_overflow = 1'b0;
    i_clear    = 1'b1;
    tick();
    i_clear = 1'b0;
    check("coll_count",  32'(o_ovf_count), 32'd0);
    check("coll_sticky", 32'(o_sticky),    32'd0);
    check("coll_state",  32'(o_state),     32'd0);
    check("coll_high",   32'(o_high),      32'd1);
    tick();
    check("coll_after_count", 32'(o_ovf_count), 32'd0);
    check("coll_after_state", 32'(o_state),     32'd1);

    // Asynchronous reset in the middle of an alarm, between clock edges.
    i_data     = 6'd63;
    i_overflow = 1'b1;
    tick();
    tick();
    check("arst_pre_alarm", 32'(o_alarm), 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_count",  32'(o_ovf_count), 32'd0);
    check("arst_sticky", 32'(o_sticky),    32'd0);
    check("arst_high",   32'(o_high),      32'd0);
    check("arst_alarm",  32'(o_alarm),     32'd0);
    check("arst_state",  32'(o_state),     32'd0);
    tick();
    i_rst_n = 1'b1;
    // Overflow still high at the first edge after reset counts as a rise.
    tick();
    tick();
    check("post_rst_count", 32'(o_ovf_count), 32'd1);
    check("post_rst_state", 32'(o_state),     32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
